pc_gen: RTL and testbench

//  Fetch PC generator with gshare direction predictor and direct-mapped BTB. Drives the next

---
 rtl/pc_gen_pkg.sv | 20 ++
 rtl/branch_target_buffer.sv | 48 ++++
 rtl/pc_gen.sv | 153 +++++++++++++++
 tb/tb_pc_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types for the fetch PC generator.
// Holds width-independent types only; entry widths live in the modules.
package pc_gen_pkg;

  typedef logic [1:0] sat2_t;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam sat2_t WEAK_NT = 2'b01;

  // Saturating 2-bit counter step: up on taken, down otherwise.
  function automatic sat2_t sat2_step(sat2_t c, logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB, 1 read, 1 write, 1 clear port.
// Ports: clk; clr_i/clr_idx_i invalidate; rd_* lookup -> hit_o/target_o;
// we_i/wr_* install entry. Reads return the pre-write value.
module branch_target_buffer
  import pc_gen_pkg::*;
#(
  parameter int BW_ADDRESS = 32,
  parameter int BW_IDX     = 4
) (
  input  logic                           clk,
  input  logic                           clr_i,
  input  logic [BW_IDX-1:0]              clr_idx_i,
  input  logic [BW_IDX-1:0]              rd_idx_i,
  input  logic [BW_ADDRESS-BW_IDX-3:0]   rd_tag_i,
  output logic                           hit_o,
  output logic [BW_ADDRESS-1:0]          target_o,
  input  logic                           we_i,
  input  logic [BW_IDX-1:0]              wr_idx_i,
  input  logic [BW_ADDRESS-BW_IDX-3:0]   wr_tag_i,
  input  logic [BW_ADDRESS-1:0]          wr_target_i
);

  localparam int BW_TAG = BW_ADDRESS - BW_IDX - 2;

  typedef struct packed {
    logic                  valid;
    logic [BW_TAG-1:0]     tag;
    logic [BW_ADDRESS-1:0] target;
  } btb_entry_t;

  btb_entry_t mem_q [2**BW_IDX];
  btb_entry_t rd;

  assign rd       = mem_q[rd_idx_i];
  assign hit_o    = rd.valid && (rd.tag == rd_tag_i);
  assign target_o = rd.target;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      mem_q[clr_idx_i] <= '0;
    end else if (we_i) begin
      mem_q[wr_idx_i] <= '{valid:  1'b1,
                           tag:    wr_tag_i,
                           target: wr_target_i};
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator, gshare PHT + direct-mapped BTB.
// Ports: clk, rst; i_bu_* resolution; o_fetch_*/i_fetch_ready handshake.
// Option PC_GEN_PERF_CNT_EN adds o_perf_branches / o_perf_mispredicts.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                    BW_ADDRESS         = 32,
  parameter int                    NUM_GLOBAL_HISTORY = 4,
  parameter int                    BW_PHT_IDX         = 6,
  parameter int                    BW_BTB_IDX         = 4,
  parameter logic [BW_ADDRESS-1:0] RESET_PC           = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_bu_valid,
  input  logic [BW_ADDRESS-1:0]         i_bu_pc,
  input  logic [BW_ADDRESS-1:0]         i_bu_correct_pc_next,
  input  logic [NUM_GLOBAL_HISTORY-1:0] i_bu_global_history,
  input  logic                          i_bu_correct_prediction,
  output logic                          o_fetch_valid,
  input  logic                          i_fetch_ready,
  output logic [BW_ADDRESS-1:0]         o_fetch_pc,
  output logic [BW_ADDRESS-1:0]         o_fetch_pc_next,
  output logic [NUM_GLOBAL_HISTORY-1:0] o_fetch_global_history
`ifdef PC_GEN_PERF_CNT_EN
  ,
  output logic [31:0]                   o_perf_branches,
  output logic [31:0]                   o_perf_mispredicts
`endif
);

  localparam int N     = NUM_GLOBAL_HISTORY;
  localparam int CLR_W = (BW_PHT_IDX > BW_BTB_IDX) ? BW_PHT_IDX
                                                   : BW_BTB_IDX;
  localparam int BW_TAG = BW_ADDRESS - BW_BTB_IDX - 2;

  state_t                state_q;
  logic [CLR_W-1:0]      clr_cnt_q;
  logic [BW_ADDRESS-1:0] pc_q, pc_d;
  logic [N-1:0]          ghr_q, ghr_d;
  sat2_t                 pht_q [2**BW_PHT_IDX];

  logic                  run, clearing;
  logic [BW_PHT_IDX-1:0] pht_idx, bu_pht_idx;
  logic                  btb_hit, pred_taken;
  logic [BW_ADDRESS-1:0] btb_target;
  logic                  bu_fire, bu_taken, flush, fire;

  assign run      = (state_q == RUN);
  assign clearing = (state_q == CLEAR);

  // gshare lookup off the current PC register
  assign pht_idx    = pc_q[BW_PHT_IDX+1:2] ^ BW_PHT_IDX'(ghr_q);
  assign pred_taken = btb_hit && pht_q[pht_idx][1];

  assign bu_fire    = run && i_bu_valid;
  assign bu_taken   = i_bu_correct_pc_next != (i_bu_pc + BW_ADDRESS'(4));
  assign bu_pht_idx = i_bu_pc[BW_PHT_IDX+1:2]
                    ^ BW_PHT_IDX'(i_bu_global_history);
  assign flush      = bu_fire && !i_bu_correct_prediction;

  // a redirect kills the offered PC in the same cycle
  assign o_fetch_valid = run && !flush;
  assign fire          = o_fetch_valid && i_fetch_ready;

  assign o_fetch_pc             = pc_q;
  assign o_fetch_global_history = ghr_q;
  assign o_fetch_pc_next = pred_taken ? btb_target
                                      : pc_q + BW_ADDRESS'(4);

  branch_target_buffer #(
    .BW_ADDRESS (BW_ADDRESS),
    .BW_IDX     (BW_BTB_IDX)
  ) u_btb (
    .clk         (clk),
    .clr_i       (clearing),
    .clr_idx_i   (clr_cnt_q[BW_BTB_IDX-1:0]),
    .rd_idx_i    (pc_q[BW_BTB_IDX+1:2]),
    .rd_tag_i    (pc_q[BW_ADDRESS-1:BW_BTB_IDX+2]),
    .hit_o       (btb_hit),
    .target_o    (btb_target),
    .we_i        (bu_fire && bu_taken && !rst),
    .wr_idx_i    (i_bu_pc[BW_BTB_IDX+1:2]),
    .wr_tag_i    (i_bu_pc[BW_ADDRESS-1:BW_ADDRESS-BW_TAG]),
    .wr_target_i (i_bu_correct_pc_next)
  );

  always_comb begin
    pc_d  = pc_q;
    ghr_d = ghr_q;
    unique case (1'b1)
      flush: begin
        pc_d  = i_bu_correct_pc_next;
        ghr_d = {i_bu_global_history[N-2:0], bu_taken};
      end
      fire: begin
        pc_d = o_fetch_pc_next;
        if (btb_hit) ghr_d = {ghr_q[N-2:0], pred_taken};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      pc_q      <= RESET_PC;
      ghr_q     <= '0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + CLR_W'(1);
          pc_q      <= RESET_PC;
          ghr_q     <= '0;
          if (&clr_cnt_q) state_q <= RUN;
        end
        RUN: begin
          pc_q  <= pc_d;
          ghr_q <= ghr_d;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // PHT storage: swept to weak-NT while clearing, trained in RUN
  always_ff @(posedge clk) begin
    if (clearing) begin
      pht_q[clr_cnt_q[BW_PHT_IDX-1:0]] <= WEAK_NT;
    end else if (bu_fire && !rst) begin
      pht_q[bu_pht_idx] <= sat2_step(pht_q[bu_pht_idx], bu_taken);
    end
  end

`ifdef PC_GEN_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mp_q;

  always_ff @(posedge clk) begin
    if (rst || clearing) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (bu_fire) perf_br_q <= perf_br_q + 32'd1;
      if (flush)   perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign o_perf_branches    = perf_br_q;
  assign o_perf_mispredicts = perf_mp_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen.
// Define PC_GEN_PERF_CNT_EN to also exercise the perf counters.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_bu_valid;
  logic [31:0] i_bu_pc;
  logic [31:0] i_bu_correct_pc_next;
  logic [3:0]  i_bu_global_history;
  logic        i_bu_correct_prediction;
  logic        o_fetch_valid;
  logic        i_fetch_ready;
  logic [31:0] o_fetch_pc;
  logic [31:0] o_fetch_pc_next;
  logic [3:0]  o_fetch_global_history;
`ifdef PC_GEN_PERF_CNT_EN
  logic [31:0] o_perf_branches;
  logic [31:0] o_perf_mispredicts;
`endif

  always #5 clk = ~clk;

  pc_gen dut (
    .clk                     (clk),
    .rst                     (rst),
    .i_bu_valid              (i_bu_valid),
    .i_bu_pc                 (i_bu_pc),
    .i_bu_correct_pc_next    (i_bu_correct_pc_next),
    .i_bu_global_history     (i_bu_global_history),
    .i_bu_correct_prediction (i_bu_correct_prediction),
    .o_fetch_valid           (o_fetch_valid),
    .i_fetch_ready           (i_fetch_ready),
    .o_fetch_pc              (o_fetch_pc),
    .o_fetch_pc_next         (o_fetch_pc_next),
    .o_fetch_global_history  (o_fetch_global_history)
`ifdef PC_GEN_PERF_CNT_EN
    ,
    .o_perf_branches         (o_perf_branches),
    .o_perf_mispredicts      (o_perf_mispredicts)
`endif
  );

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] pc;
    logic [31:0] nxt;
    logic [3:0]  ghr;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bu(input logic v, input logic [31:0] pc,
                    input logic [31:0] nxt, input logic [3:0] h,
                    input logic ok);
    i_bu_valid              = v;
    i_bu_pc                 = pc;
    i_bu_correct_pc_next    = nxt;
    i_bu_global_history     = h;
    i_bu_correct_prediction = ok;
  endtask

  // push expectation for this cycle, sample after inputs settle, clock
  task automatic cyc(input string tag, input logic v,
                     input logic [31:0] pc, input logic [31:0] nxt,
                     input logic [3:0] ghr);
    exp_t e;
    e.tag = tag; e.v = v; e.pc = pc; e.nxt = nxt; e.ghr = ghr;
    sb.push_back(e);
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_valid"}, 32'(o_fetch_valid), 32'(e.v));
      if (e.v) begin
        check({e.tag, "_pc"}, o_fetch_pc, e.pc);
        check({e.tag, "_next"}, o_fetch_pc_next, e.nxt);
        check({e.tag, "_ghr"}, 32'(o_fetch_global_history),
              32'(e.ghr));
      end
    end
    tick();
  endtask

  task automatic clear_phase(input string tag);
    int lo = 0;
    repeat (64) begin
      #1;
      if (!o_fetch_valid) lo++;
      tick();
    end
    check(tag, lo, 64);
  endtask

  initial begin
    rst = 1'b1;
    i_fetch_ready = 1'b1;
    bu(0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_fetch_valid), 0);
    check("rst_pc", o_fetch_pc, 0);
    check("rst_ghr", 32'(o_fetch_global_history), 0);
    rst = 1'b0;
    clear_phase("clear_low");

    cyc("s0", 1, 32'h0, 32'h4, 4'h0);
    cyc("s1", 1, 32'h4, 32'h8, 4'h0);

    bu(1, 32'h10, 32'h40, 4'h0, 0);
    cyc("flush_hs", 0, 0, 0, 0);
    bu(0, 0, 0, 0, 1);
    cyc("redir", 1, 32'h40, 32'h44, 4'b0001);

    bu(1, 32'h10, 32'h40, 4'h0, 1);
    cyc("train2", 1, 32'h44, 32'h48, 4'b0001);
    bu(1, 32'hC, 32'h10, 4'h0, 0);
    cyc("flush2", 0, 0, 0, 0);
    bu(0, 0, 0, 0, 1);
    cyc("pred_t", 1, 32'h10, 32'h40, 4'b0000);

    bu(1, 32'h10, 32'h40, 4'h0, 1);
    cyc("ghr_sh", 1, 32'h40, 32'h44, 4'b0001);
    bu(1, 32'hC, 32'h10, 4'h0, 0);
    cyc("flush3", 0, 0, 0, 0);
    bu(0, 0, 0, 0, 1);
    cyc("sat_hi", 1, 32'h10, 32'h40, 4'b0000);

    bu(1, 32'h1C, 32'h20, 4'b0110, 0);
    cyc("flush4", 0, 0, 0, 0);
    bu(0, 0, 0, 0, 1);
    i_fetch_ready = 1'b0;
    repeat (5) cyc("stall", 1, 32'h20, 32'h24, 4'b1100);
    i_fetch_ready = 1'b1;
    cyc("resume", 1, 32'h20, 32'h24, 4'b1100);
    cyc("resume2", 1, 32'h24, 32'h28, 4'b1100);

    rst = 1'b1;
    tick();
    check("rst2_valid", 32'(o_fetch_valid), 0);
    check("rst2_pc", o_fetch_pc, 0);
    check("rst2_ghr", 32'(o_fetch_global_history), 0);
    rst = 1'b0;
    clear_phase("clear2_low");
`ifdef PC_GEN_PERF_CNT_EN
    check("perf_br0", o_perf_branches, 0);
    check("perf_mp0", o_perf_mispredicts, 0);
`endif
    cyc("r0", 1, 32'h0, 32'h4, 4'h0);
    cyc("r1", 1, 32'h4, 32'h8, 4'h0);
    cyc("r2", 1, 32'h8, 32'hC, 4'h0);
    cyc("r3", 1, 32'hC, 32'h10, 4'h0);
    cyc("btb_gone", 1, 32'h10, 32'h14, 4'h0);

    bu(1, 32'h100, 32'h104, 4'h0, 1);
    cyc("pb0", 1, 32'h14, 32'h18, 4'h0);
    bu(1, 32'h200, 32'h240, 4'h0, 1);
    cyc("pb1", 1, 32'h18, 32'h1C, 4'h0);
    bu(1, 32'h30, 32'h80, 4'h0, 0);
    cyc("pb2", 0, 0, 0, 0);
    bu(0, 0, 0, 0, 1);
`ifdef PC_GEN_PERF_CNT_EN
    check("perf_br", o_perf_branches, 3);
    check("perf_mp", o_perf_mispredicts, 1);
`endif
    cyc("after", 1, 32'h80, 32'h84, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
